// File: rtl/dmem_responder.sv
// dmem_responder
//   Word-organised data memory answering the CPU core's DMEM port. A byte
//   address is decoded against BASE. Reads are combinational and writes are
//   posted at the clock edge. After every reset the RAM is zeroed by a
//   one-word-per-cycle sweep, and busy stays high until that sweep is done.
//   Requests that fall outside the window or are misaligned raise a sticky
//   error flag and capture the address. Accepted reads and writes are
//   counted for debug.
//
// Ports
//   clk, rst   clock and synchronous active-high reset
//   DM_ena     request valid; DM_R / DM_W are read / write strobes
//   DM_addr    byte address; DM_wdata is the write data
//   DM_rdata   read data, combinational, zero when no valid read
//   busy       high while the clear sweep runs
//   err        sticky invalid-access flag; err_addr holds the first bad address
//   rd_cnt     accepted read count, wraps
//   wr_cnt     accepted write count, wraps
module dmem_responder #(
    parameter logic [31:0] BASE   = 32'h1001_0000,
    parameter int          ADDR_W = 10,
    parameter int          CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DM_ena,
    input  logic              DM_R,
    input  logic              DM_W,
    input  logic [31:0]       DM_addr,
    input  logic [31:0]       DM_wdata,
    output logic [31:0]       DM_rdata,
    output logic              busy,
    output logic              err,
    output logic [31:0]       err_addr,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [31:0]       mem [DEPTH];

    logic [31:0]       off;
    logic              valid;
    logic [ADDR_W-1:0] idx;
    logic              ready;
    logic              rd_ok, wr_ok, bad;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [31:0]       mem_wd;

    // Modulo subtraction means an address below BASE wraps to a huge offset
    // and fails the high-bit check.
    assign off   = DM_addr - BASE;
    assign valid = (off[1:0] == 2'b00) && (off[31:ADDR_W+2] == '0);
    assign idx   = off[ADDR_W+1:2];

    assign ready = (state == READY);
    assign rd_ok = ready && DM_ena && DM_R && valid;
    assign wr_ok = ready && DM_ena && DM_W && valid;
    assign bad   = ready && DM_ena && (DM_R || DM_W) && !valid;

    // Asynchronous read shows the pre-write word when R and W coincide.
    assign DM_rdata = rd_ok ? mem[idx] : 32'h0;
    assign busy     = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (&clr_ptr) next_state = READY;
            READY:   next_state = READY;
            default: next_state = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_ptr  <= '0;
            err      <= 1'b0;
            err_addr <= 32'h0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
        end else begin
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + ADDR_W'(1);
            end
            if (bad) begin
                err <= 1'b1;
                if (!err) begin
                    err_addr <= DM_addr;
                end
            end
            if (rd_ok) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
            if (wr_ok) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
        end
    end

    // Single write port shared between the clear sweep and CPU writes.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = idx;
        mem_wd = DM_wdata;
        if (state == CLEAR) begin
            mem_we = 1'b1;
            mem_wa = clr_ptr;
            mem_wd = 32'h0;
        end else if (wr_ok) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_wa] <= mem_wd;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        DM_ena, DM_R, DM_W;
    logic [31:0] DM_addr, DM_wdata, DM_rdata;
    logic        busy, err;
    logic [31:0] err_addr;
    logic [15:0] rd_cnt, wr_cnt;

    always #5 clk = ~clk;

    dmem_responder #(
        .BASE  (32'h1001_0000),
        .ADDR_W(10),
        .CNT_W (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .DM_ena  (DM_ena),
        .DM_R    (DM_R),
        .DM_W    (DM_W),
        .DM_addr (DM_addr),
        .DM_wdata(DM_wdata),
        .DM_rdata(DM_rdata),
        .busy    (busy),
        .err     (err),
        .err_addr(err_addr),
        .rd_cnt  (rd_cnt),
        .wr_cnt  (wr_cnt)
    );

    typedef struct {
        logic        ena, r, w;
        logic [31:0] addr, wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_err_addr;
        logic [15:0] exp_rd, exp_wr;
    } vec_t;

    vec_t vecs[16];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic ena, input logic r, input logic w,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input logic [31:0] exp_err_addr,
                                input logic [15:0] exp_rd, input logic [15:0] exp_wr);
        vec_t v;
        v.ena = ena; v.r = r; v.w = w; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_err_addr = exp_err_addr;
        v.exp_rd = exp_rd; v.exp_wr = exp_wr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        DM_ena = 1'b0; DM_R = 1'b0; DM_W = 1'b0;
        DM_addr = 32'h0; DM_wdata = 32'h0;
    endtask

    // Pulse reset for one clock and return at the release edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts negedges with busy high, starting at the reset release; bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic apply(input vec_t v, input int i);
        vec_t e;
        @(negedge clk);
        DM_ena = v.ena; DM_R = v.r; DM_W = v.w;
        DM_addr = v.addr; DM_wdata = v.wdata;
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        chk($sformatf("v%0d_rdata", i), DM_rdata, e.exp_rdata);
        @(posedge clk);
        #1;
        idle_inputs();
        chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, e.exp_err});
        chk($sformatf("v%0d_err_addr", i), err_addr, e.exp_err_addr);
        chk($sformatf("v%0d_rd_cnt", i), {16'h0, rd_cnt}, {16'h0, e.exp_rd});
        chk($sformatf("v%0d_wr_cnt", i), {16'h0, wr_cnt}, {16'h0, e.exp_wr});
    endtask

    initial begin
        int n;

        //         ena r  w  addr           wdata          rdata          err  err_addr       rd  wr
        vecs[0]  = mk(1, 0, 1, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0,         0, 32'h0,         0,  1);
        vecs[1]  = mk(1, 1, 0, 32'h1001_0004, 32'h0,         32'hDEAD_BEEF, 0, 32'h0,         1,  1);
        vecs[2]  = mk(1, 1, 0, 32'h1001_0000, 32'h0,         32'h0,         0, 32'h0,         2,  1);
        vecs[3]  = mk(1, 0, 1, 32'h1001_0FFC, 32'h1234_5678, 32'h0,         0, 32'h0,         2,  2);
        vecs[4]  = mk(1, 1, 0, 32'h1001_0FFC, 32'h0,         32'h1234_5678, 0, 32'h0,         3,  2);
        vecs[5]  = mk(1, 1, 1, 32'h1001_0008, 32'hA5A5_A5A5, 32'h0,         0, 32'h0,         4,  3);
        vecs[6]  = mk(1, 1, 0, 32'h1001_0008, 32'h0,         32'hA5A5_A5A5, 0, 32'h0,         5,  3);
        vecs[7]  = mk(0, 1, 1, 32'h1001_0008, 32'h0,         32'h0,         0, 32'h0,         5,  3);
        vecs[8]  = mk(1, 1, 0, 32'h1001_0008, 32'h0,         32'hA5A5_A5A5, 0, 32'h0,         6,  3);
        vecs[9]  = mk(1, 0, 1, 32'h1001_1000, 32'h1111_1111, 32'h0,         1, 32'h1001_1000, 6,  3);
        vecs[10] = mk(1, 1, 0, 32'h1001_1000, 32'h0,         32'h0,         1, 32'h1001_1000, 6,  3);
        vecs[11] = mk(1, 1, 0, 32'h0000_0000, 32'h0,         32'h0,         1, 32'h1001_1000, 6,  3);
        vecs[12] = mk(1, 0, 1, 32'h1001_0002, 32'hFFFF_FFFF, 32'h0,         1, 32'h1001_1000, 6,  3);
        vecs[13] = mk(1, 1, 0, 32'h1001_0000, 32'h0,         32'h0,         1, 32'h1001_1000, 7,  3);
        vecs[14] = mk(1, 1, 0, 32'h1001_0FFC, 32'h0,         32'h1234_5678, 1, 32'h1001_1000, 8,  3);
        vecs[15] = mk(1, 1, 0, 32'h1000_FFFC, 32'h0,         32'h0,         1, 32'h1001_1000, 8,  3);

        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);

        // Reset and clear sweep length
        do_reset();
        chk("rst_busy", {31'h0, busy}, 32'h1);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_rd_cnt", {16'h0, rd_cnt}, 32'h0);
        chk("rst_wr_cnt", {16'h0, wr_cnt}, 32'h0);
        count_busy(n);
        chk("sweep_len", n, 32'd1024);

        // Table of single-cycle accesses
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i], i);
        end

        // Reset mid-sweep with accesses issued while clearing
        do_reset();
        repeat (300) @(negedge clk);
        DM_ena = 1'b1; DM_R = 1'b1; DM_W = 1'b1;
        DM_addr = 32'h1001_0004; DM_wdata = 32'h0000_0055;
        #2;
        chk("clr_rdata", DM_rdata, 32'h0);
        @(posedge clk);
        #1;
        DM_addr = 32'h1001_1000;
        @(posedge clk);
        #1;
        idle_inputs();
        chk("clr_wr_cnt", {16'h0, wr_cnt}, 32'h0);
        chk("clr_rd_cnt", {16'h0, rd_cnt}, 32'h0);
        chk("clr_err", {31'h0, err}, 32'h0);
        chk("clr_busy", {31'h0, busy}, 32'h1);
        repeat (197) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(n);
        chk("resweep_len", n, 32'd1024);
        chk("resweep_err", {31'h0, err}, 32'h0);
        chk("resweep_wr_cnt", {16'h0, wr_cnt}, 32'h0);

        // Earlier data must have been swept away and the dropped write absent
        @(negedge clk);
        DM_ena = 1'b1; DM_R = 1'b1; DM_addr = 32'h1001_0004;
        #2;
        chk("post_rd_0004", DM_rdata, 32'h0);
        DM_addr = 32'h1001_0FFC;
        #1;
        chk("post_rd_0FFC", DM_rdata, 32'h0);
        @(posedge clk);
        #1;
        idle_inputs();
        chk("post_rd_cnt", {16'h0, rd_cnt}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
